// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//
// Load/store front end between an RV32I-style pipeline and a word-wide
// cache port. It shifts store data and byte enables into their lanes,
// extracts and extends load data, and handles accesses that straddle a
// word boundary.
//
// Build option:
//   MISALIGN_SPLIT_EN  defined   -> a word-crossing access becomes two
//                                    cache cycles (word A, then A+1).
//                      undefined -> a word-crossing access is rejected
//                                    with misalign_err and never touches
//                                    the cache.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   req_valid/req_ready request handshake (accept when both high)
//   req_we              1 = store, 0 = load
//   req_type            funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_addr            byte address
//   req_wdata           store data, right-aligned
//   resp_valid          one-cycle completion pulse
//   resp_rdata          extended load data (0 for stores/errors/idle)
//   misalign_err        access rejected (only together with resp_valid)
//   cache_we            per-byte write enables
//   cache_addr          word address (byte address bits [31:2])
//   cache_wdata         lane-aligned store data
//   cache_rdata         read word, valid one cycle after cache_addr
module mem_access_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        misalign_err,
    output logic [3:0]  cache_we,
    output logic [29:0] cache_addr,
    output logic [31:0] cache_wdata,
    input  logic [31:0] cache_rdata
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_SPLIT2 = 1'b1;

    logic [0:0]  state_q,      state_d;
    logic        resp_valid_q, resp_valid_d;
    logic        misalign_q,   misalign_d;
    logic        split_q,      split_d;      // response is built from two words
    logic        we_q,         we_d;
    logic [2:0]  type_q,       type_d;
    logic [1:0]  off_q,        off_d;
    logic [29:0] addr_hi_q,    addr_hi_d;    // word A+1 (wraps mod 2^30)
    logic [3:0]  mask_hi_q,    mask_hi_d;
    logic [31:0] wdata_hi_q,   wdata_hi_d;
    logic [31:0] word_a_q,     word_a_d;     // read data of word A

    logic        accept;
    logic        crossing;
    logic [1:0]  req_off;
    logic [2:0]  req_size;
    logic [3:0]  size_mask;
    logic [7:0]  mask64;
    logic [63:0] wdata64;

    // Sign- or zero-extend the low bytes of an already aligned word.
    function automatic logic [31:0] load_extend(input logic [31:0] raw,
                                                input logic [2:0]  typ);
        logic [31:0] r;
        case (typ[1:0])
            2'b00:   r = typ[2] ? {24'h0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            2'b01:   r = typ[2] ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

    // Bring the addressed byte of a two-word window down to lane 0.
    function automatic logic [31:0] load_align(input logic [63:0] pair,
                                               input logic [1:0]  off);
        return 32'(pair >> {off, 3'b000});
    endfunction

    // Request decode: size, lane shift and word-crossing detection. The
    // 64-bit shifted forms give word A in the low half and A+1 in the high.
    always_comb begin
        req_off = req_addr[1:0];
        case (req_type[1:0])
            2'b00: begin
                req_size  = 3'd1;
                size_mask = 4'b0001;
            end
            2'b01: begin
                req_size  = 3'd2;
                size_mask = 4'b0011;
            end
            default: begin
                req_size  = 3'd4;
                size_mask = 4'b1111;
            end
        endcase
        crossing = ({1'b0, req_off} + req_size) > 3'd4;
        mask64   = {4'b0000, size_mask} << req_off;
        wdata64  = {32'h0, req_wdata} << {req_off, 3'b000};
    end

    assign req_ready = !rst && (state_q == ST_IDLE);
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d      = state_q;
        resp_valid_d = 1'b0;
        misalign_d   = 1'b0;
        split_d      = 1'b0;
        we_d         = we_q;
        type_d       = type_q;
        off_d        = off_q;
        addr_hi_d    = addr_hi_q;
        mask_hi_d    = mask_hi_q;
        wdata_hi_d   = wdata_hi_q;
        word_a_d     = word_a_q;
        cache_we     = 4'b0000;
        cache_addr   = req_addr[31:2];
        cache_wdata  = 32'h0;

        case (state_q)
            ST_SPLIT2: begin
                // Second half of a crossing access; reset drops the write.
                cache_addr = addr_hi_q;
                word_a_d   = cache_rdata;
                if (we_q && !rst) begin
                    cache_we    = mask_hi_q;
                    cache_wdata = wdata_hi_q;
                end
                resp_valid_d = 1'b1;
                split_d      = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                if (accept) begin
                    we_d       = req_we;
                    type_d     = req_type;
                    off_d      = req_off;
                    addr_hi_d  = req_addr[31:2] + 30'd1;
                    mask_hi_d  = mask64[7:4];
                    wdata_hi_d = wdata64[63:32];
                    if (!crossing) begin
                        resp_valid_d = 1'b1;
                        if (req_we) begin
                            cache_we    = mask64[3:0];
                            cache_wdata = wdata64[31:0];
                        end
                    end else begin
`ifdef MISALIGN_SPLIT_EN
                        state_d = ST_SPLIT2;
                        if (req_we) begin
                            cache_we    = mask64[3:0];
                            cache_wdata = wdata64[31:0];
                        end
`else
                        resp_valid_d = 1'b1;
                        misalign_d   = 1'b1;
`endif
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
            split_q      <= 1'b0;
            we_q         <= 1'b0;
            type_q       <= 3'b000;
            off_q        <= 2'b00;
            addr_hi_q    <= 30'h0;
            mask_hi_q    <= 4'b0000;
            wdata_hi_q   <= 32'h0;
            word_a_q     <= 32'h0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            misalign_q   <= misalign_d;
            split_q      <= split_d;
            we_q         <= we_d;
            type_q       <= type_d;
            off_q        <= off_d;
            addr_hi_q    <= addr_hi_d;
            mask_hi_q    <= mask_hi_d;
            wdata_hi_q   <= wdata_hi_d;
            word_a_q     <= word_a_d;
        end
    end

    assign resp_valid   = resp_valid_q;
    assign misalign_err = misalign_q;

    // Load data comes straight off cache_rdata in the response cycle.
    always_comb begin
        resp_rdata = 32'h0;
        if (resp_valid_q && !misalign_q && !we_q) begin
            resp_rdata = load_extend(
                load_align(split_q ? {cache_rdata, word_a_q} : {32'h0, cache_rdata}, off_q),
                type_q);
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_type;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        misalign_err;
    logic [3:0]  cache_we;
    logic [29:0] cache_addr;
    logic [31:0] cache_wdata;
    logic [31:0] cache_rdata;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] rdata;
    } exp_t;
    exp_t exp_q[$];

    bit [31:0] mem [bit [29:0]];

    logic [3:0]  t_we;
    logic [29:0] t_addr;
    logic [31:0] t_wd;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_type     (req_type),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .misalign_err (misalign_err),
        .cache_we     (cache_we),
        .cache_addr   (cache_addr),
        .cache_wdata  (cache_wdata),
        .cache_rdata  (cache_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cache model: synchronous read (old data), byte-enabled write.
    always @(posedge clk) begin
        bit [31:0] w;
        cyc <= cyc + 1;
        w = mem.exists(cache_addr) ? mem[cache_addr] : 32'h0;
        cache_rdata <= w;
        if (cache_we != 4'b0000) begin
            for (int b = 0; b < 4; b++)
                if (cache_we[b]) w[8*b +: 8] = cache_wdata[8*b +: 8];
            mem[cache_addr] = w;
        end
    end

    // Response side of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (resp_valid === 1'b1) begin
                chk("resp_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("resp_cycle", 64'(cyc), 64'(e.cyc));
                    chk("resp_err", 64'(misalign_err), 64'(e.err));
                    chk("resp_rdata", 64'(resp_rdata), 64'(e.rdata));
                end
            end else begin
                chk("no_resp_valid", 64'(resp_valid), 64'd0);
                chk("no_resp_rdata", 64'(resp_rdata), 64'd0);
                chk("no_resp_err", 64'(misalign_err), 64'd0);
            end
        end
    end

    task automatic issue(input logic we, input logic [2:0] ty, input logic [31:0] a,
                         input logic [31:0] d, input bit want_resp, input int lat,
                         input logic err, input logic [31:0] rd);
        exp_t e;
        req_valid = 1'b1;
        req_we    = we;
        req_type  = ty;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
        chk("accept_ready", 64'(req_ready), 64'd1);
        t_we   = cache_we;
        t_addr = cache_addr;
        t_wd   = cache_wdata;
        if (want_resp) begin
            e.cyc   = cyc + lat;
            e.err   = err;
            e.rdata = rd;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'($urandom_range(0, 1));
        req_type  = 3'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    task automatic cache_chk(input string tag, input logic [3:0] we,
                             input logic [29:0] a, input logic [31:0] wd);
        chk({tag, "_we"},    64'(t_we),   64'(we));
        chk({tag, "_addr"},  64'(t_addr), 64'(a));
        chk({tag, "_wdata"}, 64'(t_wd),   64'(wd));
    endtask

    // Observe the cycle after a crossing accept (DUT busy in second half).
    task automatic split_cycle(input string tag, input logic [3:0] we,
                               input logic [29:0] a, input logic [31:0] wd);
        @(negedge clk);
        chk({tag, "_busy"}, 64'(req_ready), 64'd0);
        t_we   = cache_we;
        t_addr = cache_addr;
        t_wd   = cache_wdata;
        cache_chk(tag, we, a, wd);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_type  = 3'b010;
        req_addr  = 32'h100;
        req_wdata = 32'hFFFF_FFFF;
        repeat (2) begin
            @(negedge clk);
            chk("rst_ready", 64'(req_ready), 64'd0);
            chk("rst_cache_we", 64'(cache_we), 64'd0);
        end
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'h1234_5678;
        @(negedge clk);
        chk("idle_ready", 64'(req_ready), 64'd1);
        chk("idle_we",    64'(cache_we), 64'd0);
        chk("idle_addr",  64'(cache_addr), 64'h048D159E);
        chk("idle_wdata", 64'(cache_wdata), 64'd0);
        @(posedge clk);
        #1;

        // Word store/load, back to back.
        issue(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 1'b1, 1, 1'b0, 32'h0);
        cache_chk("sw_100", 4'hF, 30'h40, 32'hDEAD_BEEF);
        issue(1'b0, 3'b010, 32'h100, 32'h0, 1'b1, 1, 1'b0, 32'hDEAD_BEEF);
        cache_chk("lw_100", 4'h0, 30'h40, 32'h0);

        // Byte store in top lane, signed and unsigned reloads.
        issue(1'b1, 3'b000, 32'h103, 32'h80, 1'b1, 1, 1'b0, 32'h0);
        cache_chk("sb_103", 4'h8, 30'h40, 32'h8000_0000);
        issue(1'b0, 3'b000, 32'h103, 32'h0, 1'b1, 1, 1'b0, 32'hFFFF_FF80);
        issue(1'b0, 3'b100, 32'h103, 32'h0, 1'b1, 1, 1'b0, 32'h0000_0080);
        @(posedge clk);
        #1;
        issue(1'b0, 3'b000, 32'h101, 32'h0, 1'b1, 1, 1'b0, 32'hFFFF_FFBE);
        issue(1'b0, 3'b100, 32'h102, 32'h0, 1'b1, 1, 1'b0, 32'h0000_00AD);
        issue(1'b0, 3'b101, 32'h100, 32'h0, 1'b1, 1, 1'b0, 32'h0000_BEEF);
        issue(1'b0, 3'b001, 32'h102, 32'h0, 1'b1, 1, 1'b0, 32'hFFFF_80AD);

        // Halfword lanes.
        issue(1'b1, 3'b001, 32'h106, 32'hABCD_8001, 1'b1, 1, 1'b0, 32'h0);
        cache_chk("sh_106", 4'hC, 30'h41, 32'h8001_0000);
        issue(1'b0, 3'b001, 32'h106, 32'h0, 1'b1, 1, 1'b0, 32'hFFFF_8001);
        issue(1'b0, 3'b101, 32'h106, 32'h0, 1'b1, 1, 1'b0, 32'h0000_8001);
        issue(1'b0, 3'b001, 32'h105, 32'h0, 1'b1, 1, 1'b0, 32'h0000_0100);

        // Unsigned bit is ignored for stores.
        issue(1'b1, 3'b101, 32'h108, 32'h0000_1234, 1'b1, 1, 1'b0, 32'h0);
        cache_chk("sh_u_108", 4'h3, 30'h42, 32'h0000_1234);
        issue(1'b1, 3'b100, 32'h10A, 32'h0000_005A, 1'b1, 1, 1'b0, 32'h0);
        cache_chk("sb_u_10a", 4'h4, 30'h42, 32'h005A_0000);
        issue(1'b0, 3'b010, 32'h108, 32'h0, 1'b1, 1, 1'b0, 32'h005A_1234);

`ifdef MISALIGN_SPLIT_EN
        issue(1'b1, 3'b010, 32'h202, 32'h1122_3344, 1'b1, 2, 1'b0, 32'h0);
        cache_chk("sw_202_a", 4'hC, 30'h80, 32'h3344_0000);
        split_cycle("sw_202_b", 4'h3, 30'h81, 32'h0000_1122);
        issue(1'b0, 3'b010, 32'h202, 32'h0, 1'b1, 2, 1'b0, 32'h1122_3344);
        cache_chk("lw_202_a", 4'h0, 30'h80, 32'h0);
        split_cycle("lw_202_b", 4'h0, 30'h81, 32'h0);
        issue(1'b0, 3'b001, 32'h107, 32'h0, 1'b1, 2, 1'b0, 32'h0000_3480);
        split_cycle("lh_107_b", 4'h0, 30'h42, 32'h0);

        // Word address wraps to zero.
        issue(1'b1, 3'b010, 32'hFFFF_FFFE, 32'hA5A5_5A5A, 1'b1, 2, 1'b0, 32'h0);
        cache_chk("sw_wrap_a", 4'hC, 30'h3FFF_FFFF, 32'h5A5A_0000);
        split_cycle("sw_wrap_b", 4'h3, 30'h0, 32'h0000_A5A5);

        // Reset during the second half abandons the access.
        issue(1'b1, 3'b010, 32'h206, 32'hCAFE_F00D, 1'b0, 0, 1'b0, 32'h0);
        cache_chk("sw_206_a", 4'hC, 30'h81, 32'hF00D_0000);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_split_we", 64'(cache_we), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        issue(1'b0, 3'b010, 32'h208, 32'h0, 1'b1, 1, 1'b0, 32'h0);
        issue(1'b0, 3'b010, 32'h204, 32'h0, 1'b1, 1, 1'b0, 32'hF00D_1122);
`else
        // Crossing accesses are rejected without touching the cache.
        issue(1'b0, 3'b001, 32'h107, 32'h0, 1'b1, 1, 1'b1, 32'h0);
        cache_chk("lh_107", 4'h0, 30'h41, 32'h0);
        issue(1'b1, 3'b010, 32'h202, 32'h1122_3344, 1'b1, 1, 1'b1, 32'h0);
        cache_chk("sw_202", 4'h0, 30'h80, 32'h0);
        issue(1'b0, 3'b010, 32'h200, 32'h0, 1'b1, 1, 1'b0, 32'h0);
        issue(1'b0, 3'b010, 32'h204, 32'h0, 1'b1, 1, 1'b0, 32'h0);
        issue(1'b0, 3'b010, 32'h101, 32'h0, 1'b1, 1, 1'b1, 32'h0);
        issue(1'b1, 3'b001, 32'h10F, 32'h0000_7777, 1'b1, 1, 1'b1, 32'h0);
        cache_chk("sh_10f", 4'h0, 30'h43, 32'h0);
        issue(1'b0, 3'b010, 32'h10C, 32'h0, 1'b1, 1, 1'b0, 32'h0);
`endif

        begin
            int w;
            w = 0;
            while (exp_q.size() != 0 && w < 20) begin
                @(negedge clk);
                w++;
            end
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
